// File: rtl/issue_ctrl_s.sv
// In-order issue control with a small destination scoreboard.
// Blocks RAW/WAW hazards, selects ALU-writeback forwarding and drains on flush.
module issue_ctrl_s #(
    parameter int NUM_ENTRY = 4,
    parameter int WIDTH_IDX = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Req,
    input  logic [WIDTH_IDX-1:0] I_Src_Idx1,
    input  logic [WIDTH_IDX-1:0] I_Src_Idx2,
    input  logic [WIDTH_IDX-1:0] I_Src_Idx3,
    input  logic [2:0]           I_Src_Vld,
    input  logic [WIDTH_IDX-1:0] I_Dst_Idx,
    input  logic                 I_Dst_Vld,
    input  logic                 I_Flush,
    input  logic                 I_WB_Vld1,
    input  logic                 I_WB_Vld2,
    input  logic [WIDTH_IDX-1:0] I_WB_DstIdx1,
    input  logic [WIDTH_IDX-1:0] I_WB_DstIdx2,
    output logic                 O_Issue,
    output logic [1:0]           O_Fwd_Sel1,
    output logic [1:0]           O_Fwd_Sel2,
    output logic [1:0]           O_Fwd_Sel3,
    output logic [1:0]           O_State,
    output logic                 O_Full,
    output logic                 O_Empty,
    output logic                 O_Flush_Done,
    output logic [7:0]           O_Stall_Cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [NUM_ENTRY-1:0] LSB_ONE = {{(NUM_ENTRY-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [NUM_ENTRY-1:0] r_vld;
    logic [WIDTH_IDX-1:0] r_idx [NUM_ENTRY];
    logic                 r_flush_done;
    logic [7:0]           r_stall_cnt;

    logic [NUM_ENTRY-1:0] w_m1;
    logic [NUM_ENTRY-1:0] w_m2;
    logic [NUM_ENTRY-1:0] w_ret1;
    logic [NUM_ENTRY-1:0] w_ret2;
    logic [NUM_ENTRY-1:0] w_live;
    logic [NUM_ENTRY-1:0] w_free;
    logic [NUM_ENTRY-1:0] w_alloc;
    logic [2:0]           w_src_hit;
    logic                 w_dst_hit;
    logic                 w_raw;
    logic                 w_waw;
    logic                 w_no_slot;
    logic                 w_issue;
    logic                 w_alloc_en;
    logic                 w_wb1_act;
    logic                 w_wb2_act;
    logic                 w_empty;

    function automatic logic [1:0] sel_src(
        input logic [WIDTH_IDX-1:0] idx,
        input logic                 act1,
        input logic [WIDTH_IDX-1:0] wb1,
        input logic                 act2,
        input logic [WIDTH_IDX-1:0] wb2
    );
        if (act1 && idx == wb1)      return 2'd1;
        else if (act2 && idx == wb2) return 2'd2;
        else                         return 2'd0;
    endfunction

    // Per-port match vectors; port 2 skips the entry port 1 already took.
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            w_m1[i] = r_vld[i] & I_WB_Vld1 & (r_idx[i] == I_WB_DstIdx1);
            w_m2[i] = r_vld[i] & I_WB_Vld2 & (r_idx[i] == I_WB_DstIdx2);
        end
    end

    // x & -x isolates the lowest set bit: the lowest-numbered match / free slot.
    assign w_ret1    = w_m1 & (~w_m1 + LSB_ONE);
    assign w_ret2    = (w_m2 & ~w_ret1) & (~(w_m2 & ~w_ret1) + LSB_ONE);
    assign w_live    = r_vld & ~(w_ret1 | w_ret2);
    assign w_free    = ~w_live;
    assign w_alloc   = w_free & (~w_free + LSB_ONE);
    assign w_wb1_act = |w_ret1;
    assign w_wb2_act = |w_ret2;
    assign w_empty   = ~|r_vld;

    always_comb begin
        w_src_hit = '0;
        w_dst_hit = 1'b0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (w_live[i]) begin
                if (r_idx[i] == I_Src_Idx1) w_src_hit[0] = 1'b1;
                if (r_idx[i] == I_Src_Idx2) w_src_hit[1] = 1'b1;
                if (r_idx[i] == I_Src_Idx3) w_src_hit[2] = 1'b1;
                if (r_idx[i] == I_Dst_Idx)  w_dst_hit    = 1'b1;
            end
        end
    end

    // Handshake: decode holds I_Req with stable operands; O_Issue high in the
    // same cycle means the request is consumed at the next rising edge.
    assign w_raw      = |(w_src_hit & I_Src_Vld);
    assign w_waw      = w_dst_hit & I_Dst_Vld;
    assign w_no_slot  = I_Dst_Vld & ~(|w_free);
    assign w_issue    = ~reset & I_Req & (r_state != ST_DRAIN) & ~w_raw & ~w_waw & ~w_no_slot;
    assign w_alloc_en = w_issue & I_Dst_Vld;

    always_comb begin
        O_Fwd_Sel1 = 2'd0;
        O_Fwd_Sel2 = 2'd0;
        O_Fwd_Sel3 = 2'd0;
        if (!reset) begin
            O_Fwd_Sel1 = sel_src(I_Src_Idx1, w_wb1_act, I_WB_DstIdx1, w_wb2_act, I_WB_DstIdx2);
            O_Fwd_Sel2 = sel_src(I_Src_Idx2, w_wb1_act, I_WB_DstIdx1, w_wb2_act, I_WB_DstIdx2);
            O_Fwd_Sel3 = sel_src(I_Src_Idx3, w_wb1_act, I_WB_DstIdx1, w_wb2_act, I_WB_DstIdx2);
        end
    end

    // Allocation wins over retirement of the same slot, so the new index survives.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                if (w_alloc_en && w_alloc[i]) begin
                    r_vld[i] <= 1'b1;
                    r_idx[i] <= I_Dst_Idx;
                end else if (w_ret1[i] || w_ret2[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_flush_done <= 1'b0;
            r_stall_cnt  <= 8'd0;
        end else begin
            r_flush_done <= 1'b0;
            if (I_Req && !w_issue && r_stall_cnt != 8'hFF) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (I_Flush) begin
                r_state <= ST_DRAIN;
            end else if (r_state == ST_DRAIN) begin
                if (w_empty) begin
                    r_state      <= ST_IDLE;
                    r_flush_done <= 1'b1;
                end
            end else if (I_Req) begin
                r_state <= w_issue ? ST_RUN : ST_STALL;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign O_Issue      = w_issue;
    assign O_State      = r_state;
    assign O_Full       = &r_vld;
    assign O_Empty      = w_empty;
    assign O_Flush_Done = r_flush_done;
    assign O_Stall_Cnt  = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl_s.sv
// Bench for issue_ctrl_s: directed scenarios then randomized traffic, all
// checked against a slot-list reference model of the scoreboard rules.
module tb_issue_ctrl_s;
    localparam int NE = 4;
    localparam int WI = 6;

    logic          clock;
    logic          reset;
    logic          I_Req;
    logic [WI-1:0] I_Src_Idx1, I_Src_Idx2, I_Src_Idx3;
    logic [2:0]    I_Src_Vld;
    logic [WI-1:0] I_Dst_Idx;
    logic          I_Dst_Vld;
    logic          I_Flush;
    logic          I_WB_Vld1, I_WB_Vld2;
    logic [WI-1:0] I_WB_DstIdx1, I_WB_DstIdx2;
    logic          O_Issue;
    logic [1:0]    O_Fwd_Sel1, O_Fwd_Sel2, O_Fwd_Sel3;
    logic [1:0]    O_State;
    logic          O_Full, O_Empty, O_Flush_Done;
    logic [7:0]    O_Stall_Cnt;

    issue_ctrl_s #(.NUM_ENTRY(NE), .WIDTH_IDX(WI)) dut (
        .clock(clock), .reset(reset), .I_Req(I_Req),
        .I_Src_Idx1(I_Src_Idx1), .I_Src_Idx2(I_Src_Idx2), .I_Src_Idx3(I_Src_Idx3),
        .I_Src_Vld(I_Src_Vld), .I_Dst_Idx(I_Dst_Idx), .I_Dst_Vld(I_Dst_Vld),
        .I_Flush(I_Flush), .I_WB_Vld1(I_WB_Vld1), .I_WB_Vld2(I_WB_Vld2),
        .I_WB_DstIdx1(I_WB_DstIdx1), .I_WB_DstIdx2(I_WB_DstIdx2),
        .O_Issue(O_Issue), .O_Fwd_Sel1(O_Fwd_Sel1), .O_Fwd_Sel2(O_Fwd_Sel2),
        .O_Fwd_Sel3(O_Fwd_Sel3), .O_State(O_State), .O_Full(O_Full),
        .O_Empty(O_Empty), .O_Flush_Done(O_Flush_Done), .O_Stall_Cnt(O_Stall_Cnt)
    );

    // clock/reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_err    = 0;

    // reference model: slot list plus state number (0 idle,1 run,2 stall,3 drain)
    bit m_v[NE];
    int m_idx[NE];
    int m_state, m_stall;
    bit m_fd, m_known;
    bit n_v[NE];
    int n_idx[NE];
    int n_state, n_stall;
    bit n_fd, n_known;
    int e_issue;
    int e_fwd[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_eval();
        int  r1, r2, fr, cnt;
        bit  live[NE];
        bit  haz, waw, empty;
        int  src[3];
        src[0] = int'(I_Src_Idx1);
        src[1] = int'(I_Src_Idx2);
        src[2] = int'(I_Src_Idx3);
        r1 = -1;
        r2 = -1;
        for (int i = 0; i < NE; i++)
            if (I_WB_Vld1 && r1 < 0 && m_v[i] && m_idx[i] == int'(I_WB_DstIdx1)) r1 = i;
        for (int i = 0; i < NE; i++)
            if (I_WB_Vld2 && r2 < 0 && i != r1 && m_v[i] && m_idx[i] == int'(I_WB_DstIdx2)) r2 = i;
        for (int i = 0; i < NE; i++) live[i] = m_v[i] && i != r1 && i != r2;
        haz = 0;
        waw = 0;
        fr  = -1;
        for (int i = 0; i < NE; i++) begin
            for (int n = 0; n < 3; n++)
                if (I_Src_Vld[n] && live[i] && m_idx[i] == src[n]) haz = 1;
            if (I_Dst_Vld && live[i] && m_idx[i] == int'(I_Dst_Idx)) waw = 1;
            if (fr < 0 && !live[i]) fr = i;
        end
        e_issue = (!reset && I_Req && m_state != 3 && !haz && !waw && !(I_Dst_Vld && fr < 0)) ? 1 : 0;
        for (int n = 0; n < 3; n++) begin
            if (reset)                                    e_fwd[n] = 0;
            else if (r1 >= 0 && src[n] == int'(I_WB_DstIdx1)) e_fwd[n] = 1;
            else if (r2 >= 0 && src[n] == int'(I_WB_DstIdx2)) e_fwd[n] = 2;
            else                                          e_fwd[n] = 0;
        end
        cnt = 0;
        for (int i = 0; i < NE; i++) cnt += m_v[i];
        empty = (cnt == 0);
        n_known = m_known || reset;
        if (reset) begin
            for (int i = 0; i < NE; i++) begin n_v[i] = 0; n_idx[i] = m_idx[i]; end
            n_state = 0;
            n_stall = 0;
            n_fd    = 0;
        end else begin
            for (int i = 0; i < NE; i++) begin n_v[i] = live[i]; n_idx[i] = m_idx[i]; end
            if (e_issue == 1 && I_Dst_Vld) begin
                n_v[fr]   = 1;
                n_idx[fr] = int'(I_Dst_Idx);
            end
            n_stall = (I_Req && e_issue == 0) ? ((m_stall == 255) ? 255 : m_stall + 1) : m_stall;
            n_fd    = (!I_Flush && m_state == 3 && empty);
            if (I_Flush)           n_state = 3;
            else if (m_state == 3) n_state = empty ? 0 : 3;
            else if (I_Req)        n_state = e_issue ? 1 : 2;
            else                   n_state = 0;
        end
    endtask

    task automatic step();
        int cnt;
        #2;
        model_eval();
        check_eq("issue", O_Issue, e_issue);
        check_eq("fwd1", O_Fwd_Sel1, e_fwd[0]);
        check_eq("fwd2", O_Fwd_Sel2, e_fwd[1]);
        check_eq("fwd3", O_Fwd_Sel3, e_fwd[2]);
        if (m_known) begin
            cnt = 0;
            for (int i = 0; i < NE; i++) cnt += m_v[i];
            check_eq("state", O_State, m_state);
            check_eq("full", O_Full, (cnt == NE) ? 1 : 0);
            check_eq("empty", O_Empty, (cnt == 0) ? 1 : 0);
            check_eq("flush_done", O_Flush_Done, m_fd ? 1 : 0);
            check_eq("stall_cnt", O_Stall_Cnt, m_stall);
        end
        @(posedge clock);
        for (int i = 0; i < NE; i++) begin m_v[i] = n_v[i]; m_idx[i] = n_idx[i]; end
        m_state = n_state;
        m_stall = n_stall;
        m_fd    = n_fd;
        m_known = n_known;
        #1;
    endtask

    // driver tasks
    task automatic clr_in();
        I_Req = 0; I_Src_Vld = 3'b000; I_Dst_Vld = 0; I_Flush = 0;
        I_Src_Idx1 = '0; I_Src_Idx2 = '0; I_Src_Idx3 = '0; I_Dst_Idx = '0;
        I_WB_Vld1 = 0; I_WB_Vld2 = 0; I_WB_DstIdx1 = '0; I_WB_DstIdx2 = '0;
    endtask

    task automatic issue_dst(input int d);
        clr_in();
        I_Req = 1; I_Dst_Vld = 1; I_Dst_Idx = 6'(d);
        step();
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic rand_cycle();
        int k;
        clr_in();
        reset      = ($urandom_range(0, 299) == 0);
        I_Req      = ($urandom_range(0, 3) != 0);
        I_Flush    = ($urandom_range(0, 24) == 0);
        I_Src_Vld  = 3'($urandom_range(0, 7));
        I_Src_Idx1 = 6'($urandom_range(0, 7));
        I_Src_Idx2 = 6'($urandom_range(0, 7));
        I_Src_Idx3 = 6'($urandom_range(0, 7));
        I_Dst_Vld  = ($urandom_range(0, 1) == 1);
        I_Dst_Idx  = 6'($urandom_range(0, 7));
        I_WB_Vld1  = ($urandom_range(0, 2) != 0);
        k = $urandom_range(0, NE - 1);
        I_WB_DstIdx1 = m_v[k] ? 6'(m_idx[k]) : 6'($urandom_range(0, 7));
        I_WB_Vld2  = ($urandom_range(0, 2) != 0);
        k = $urandom_range(0, NE - 1);
        I_WB_DstIdx2 = m_v[k] ? 6'(m_idx[k]) : 6'($urandom_range(0, 7));
        step();
    endtask

    initial begin
        m_known = 0; m_state = 0; m_stall = 0; m_fd = 0;
        for (int i = 0; i < NE; i++) begin m_v[i] = 0; m_idx[i] = 0; end
        clr_in();
        reset = 1;
        step();
        step();
        reset = 0;
        check_eq("rst_empty", O_Empty, 1);
        check_eq("rst_state", O_State, 0);

        // RAW stall on a pending destination
        issue_dst(5);
        clr_in(); I_Req = 1; I_Src_Vld = 3'b001; I_Src_Idx1 = 6'd5;
        #1 check_eq("raw_issue", O_Issue, 0);
        step();
        check_eq("raw_state", O_State, 2);
        check_eq("raw_stall_cnt", O_Stall_Cnt, 1);

        // forwarding from WB port 2 while entry 5 retires
        clr_in(); I_Req = 1; I_Src_Vld = 3'b011; I_Src_Idx1 = 6'd5; I_Src_Idx2 = 6'd5;
        I_WB_Vld2 = 1; I_WB_DstIdx2 = 6'd5;
        #1;
        check_eq("fwd_issue", O_Issue, 1);
        check_eq("fwd_sel1_wb2", O_Fwd_Sel1, 2);
        check_eq("fwd_sel2_wb2", O_Fwd_Sel2, 2);
        step();

        // full scoreboard: allocate into a slot retiring the same cycle
        for (int d = 1; d <= 4; d++) issue_dst(d);
        check_eq("fill_full", O_Full, 1);
        clr_in(); I_Req = 1; I_Dst_Vld = 1; I_Dst_Idx = 6'd9; I_WB_Vld1 = 1; I_WB_DstIdx1 = 6'd2;
        #1 check_eq("reuse_issue", O_Issue, 1);
        step();
        check_eq("reuse_full", O_Full, 1);
        clr_in(); I_Req = 1; I_Src_Vld = 3'b001; I_Src_Idx1 = 6'd9;
        #1 check_eq("reuse_holds9", O_Issue, 0);
        step();
        clr_in(); I_Req = 1; I_Src_Vld = 3'b001; I_Src_Idx1 = 6'd2;
        #1 check_eq("reuse_idx2_gone", O_Issue, 1);
        step();
        do_reset();

        // drain with both ports retiring together
        issue_dst(3);
        issue_dst(7);
        clr_in(); I_Flush = 1;
        step();
        check_eq("drain_state", O_State, 3);
        clr_in(); I_Req = 1; I_WB_Vld1 = 1; I_WB_DstIdx1 = 6'd3; I_WB_Vld2 = 1; I_WB_DstIdx2 = 6'd7;
        #1 check_eq("drain_refuse", O_Issue, 0);
        step();
        check_eq("drain_empty", O_Empty, 1);
        check_eq("drain_fd_low", O_Flush_Done, 0);
        clr_in();
        step();
        check_eq("drain_fd_pulse", O_Flush_Done, 1);
        check_eq("drain_idle", O_State, 0);
        step();
        check_eq("drain_fd_clear", O_Flush_Done, 0);
        do_reset();

        // stall counter saturation, then reset mid-stall
        issue_dst(5);
        clr_in(); I_Req = 1; I_Src_Vld = 3'b001; I_Src_Idx1 = 6'd5;
        for (int c = 0; c < 300; c++) step();
        check_eq("stall_sat", O_Stall_Cnt, 255);
        reset = 1;
        #1;
        check_eq("rst_issue", O_Issue, 0);
        check_eq("rst_fwd1", O_Fwd_Sel1, 0);
        step();
        check_eq("rst_stall_cnt", O_Stall_Cnt, 0);
        check_eq("rst_empty2", O_Empty, 1);
        check_eq("rst_fd", O_Flush_Done, 0);
        reset = 0;

        for (int c = 0; c < 2000; c++) rand_cycle();
        reset = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/issue_ctrl_s.md
ISSUE_CTRL_S -- requirements
Module: issue_ctrl_s

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 4, meaning in-flight destination slots in the scoreboard.
REQ-002 SHALL have parameter WIDTH_IDX, default 6, meaning register index width (index_t).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port I_Req  input  1  instruction request from decode.
REQ-006 SHALL have ports I_Src_Idx1/2/3  input  WIDTH_IDX each  source register indices.
REQ-007 SHALL have port I_Src_Vld  input  3  per-source valid; bit n-1 qualifies I_Src_Idxn.
REQ-008 SHALL have ports I_Dst_Idx  input  WIDTH_IDX and I_Dst_Vld  input  1  destination index and valid.
REQ-009 SHALL have port I_Flush  input  1  drain request.
REQ-010 SHALL have ports I_WB_Vld1/2  input  1 and I_WB_DstIdx1/2  input  WIDTH_IDX  ALU writeback ports.
REQ-011 SHALL have port O_Issue  output  1  request accepted this cycle; also the ack to decode.
REQ-012 SHALL have ports O_Fwd_Sel1/2/3  output  2 each  operand source: 0 RegFile, 1 WB port 1, 2 WB port 2.
REQ-013 SHALL have port O_State  output  2  FSM state: 0 IDLE, 1 RUN, 2 STALL, 3 DRAIN.
REQ-014 SHALL have ports O_Full  output  1 and O_Empty  output  1  scoreboard status.
REQ-015 SHALL have port O_Flush_Done  output  1  one-cycle pulse when drain completes.
REQ-016 SHALL have port O_Stall_Cnt  output  8  saturating count of stall cycles.

Function
REQ-017 Each scoreboard entry SHALL hold a valid bit and a WIDTH_IDX index.
REQ-018 A valid entry SHALL retire when it matches a valid WB port index.
  - At most one entry retires per WB port, the lowest-numbered matching entry.
  - Both ports SHALL retire distinct entries in the same cycle.
REQ-019 Source n SHALL be hazarded if I_Src_Vld[n-1] is set and its index matches any valid entry not retiring this cycle.
REQ-020 O_Fwd_Sel n SHALL be 1 if its index equals a retiring I_WB_DstIdx1, else 2 if it equals a retiring I_WB_DstIdx2, else 0.
  - Port 1 has priority; the value is combinational in the request cycle.
REQ-021 A WAW hazard SHALL exist if I_Dst_Vld is set and I_Dst_Idx matches a valid entry not retiring this cycle.
REQ-022 O_Issue SHALL equal I_Req AND state is not DRAIN AND no source hazard AND no WAW hazard AND NOT (I_Dst_Vld AND no free entry after this cycle's retirements).
REQ-023 On issue with I_Dst_Vld, the lowest free entry SHALL be allocated at the edge.
  - An entry retiring this cycle counts as free.
  - Allocation and retirement of the same slot in one cycle SHALL leave it valid with the new index.
REQ-024 O_Full SHALL be set when all entries are valid; O_Empty SHALL be set when none are valid (registered state).
REQ-025 FSM transitions, priority in listed order:
  - any state with I_Flush -> DRAIN.
  - DRAIN with O_Empty -> IDLE, pulsing O_Flush_Done for that cycle.
  - I_Req with O_Issue -> RUN.
  - I_Req without O_Issue -> STALL.
  - no I_Req -> IDLE.
REQ-026 In DRAIN, requests SHALL be refused; retirements continue; allocation SHALL NOT occur.
REQ-027 O_Stall_Cnt SHALL increment by 1 each cycle I_Req is set and O_Issue is clear, saturating at 255.
REQ-028 Index 0 SHALL be treated as an ordinary register with no special-casing.

Reset
REQ-029 With reset high, at the next edge all entries SHALL be cleared, the state SHALL be IDLE, O_Stall_Cnt SHALL be 0, and O_Flush_Done SHALL be 0.
REQ-030 While reset is high, O_Issue SHALL be 0 and O_Fwd_Sel1/2/3 SHALL be 0.
REQ-031 Reset mid-drain or mid-stall SHALL abandon the in-flight entries without pulsing O_Flush_Done.

Verification
REQ-032 Issue dst=5; next cycle src1=5 with no WB -> O_Issue=0, O_State=STALL next cycle, O_Stall_Cnt=1.
REQ-033 Entry 5 pending; I_WB_Vld2=1, I_WB_DstIdx2=5 while src1=5 and src2=5 request -> O_Issue=1, O_Fwd_Sel1=2, O_Fwd_Sel2=2.
REQ-034 Fill 4 entries (dst 1..4); request dst=9 while I_WB_Vld1 retires idx 2 -> O_Issue=1, entry 1 (former idx 2) now holds 9, O_Full stays 1.
REQ-035 Entries {3,7} pending; I_Flush then I_WB_Vld1 idx 3 and I_WB_Vld2 idx 7 together -> O_Empty=1 the following cycle, O_Flush_Done single pulse, then O_State=IDLE.
REQ-036 Hold a hazarded request 300 cycles -> O_Stall_Cnt=255; assert reset -> O_Stall_Cnt=0, O_Empty=1, O_Issue=0.
